// File: rtl/eq_sweep_tester.sv
// -----------------------------------------------------------------------------
// eq_sweep_tester
//
// Stimulus-and-check engine for an equality comparator.
//
// It drives every (a, b) operand pair onto a_out/b_out and holds each pair for
// SETTLE clocks. It then samples the comparator's eq_in flag for one clock and
// scores it against (a_out == b_out). The sweep order is b inner and a outer,
// so the pairs run from {0,0} up to {all ones, all ones}. Each vector takes
// SETTLE+1 clocks, and a full sweep takes 2^(2*WIDTH)*(SETTLE+1) clocks from
// the start pulse to done.
//
// Optional build macro:
//   STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep. The
//                     operand buses freeze on the failing pair.
//
// Parameters:
//   WIDTH   operand width in bits
//   SETTLE  clocks (>=1) a pair is held before eq_in is sampled
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse; honoured only in IDLE or DONE
//   a_out        operand A to the comparator
//   b_out        operand B to the comparator
//   eq_in        equal flag returned by the comparator
//   busy         high while a sweep is running
//   done         high from sweep completion until the next start
//   pass         valid with done; 1 = zero mismatches
//   err_count    number of mismatching vectors
//   match_count  number of vectors with eq_in=1 and expected=1
//   fail_a       a_out of the first mismatch
//   fail_b       b_out of the first mismatch
// -----------------------------------------------------------------------------
module eq_sweep_tester #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               eq_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH:0]   match_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int CW = 2*WIDTH + 1;
  localparam int PW = 2*WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);

  // state   | meaning
  // S_IDLE  | after reset, waiting for start
  // S_HOLD  | operand pair on the buses, settle counter running down
  // S_SAMPLE| eq_in scored against expected, pair advanced or sweep ended
  // S_DONE  | results held for readout, start re-arms a sweep
  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CW-1:0]     err_q, err_d;
  logic [CW-1:0]     match_q, match_d;
  logic [WIDTH-1:0]  fail_a_q, fail_a_d;
  logic [WIDTH-1:0]  fail_b_q, fail_b_d;

  logic              expected;
  logic              mismatch;
  logic              last_pair;
  logic              stop_now;
  logic [CW-1:0]     err_nxt;
  logic [PW-1:0]     pair_nxt;

  assign expected  = (a_q == b_q);
  assign mismatch  = (eq_in != expected);
  assign last_pair = &{a_q, b_q};
  assign err_nxt   = err_q + CW'(mismatch);
  assign pair_nxt  = {a_q, b_q} + PW'(1);

`ifdef STOP_ON_FAIL_EN
  assign stop_now = last_pair | mismatch;
`else
  assign stop_now = last_pair;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    match_d  = match_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d      = '0;
          b_d      = '0;
          settle_d = SETTLE_M1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          match_d  = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          state_d  = S_HOLD;
        end
      end

      S_HOLD: begin
        if (settle_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end

      S_SAMPLE: begin
        err_d = err_nxt;
        // Only the first mismatch is captured. err_q is still zero on that vector.
        if (mismatch && (err_q == '0)) begin
          fail_a_d = a_q;
          fail_b_d = b_q;
        end
        if (eq_in && expected) begin
          match_d = match_q + CW'(1);
        end
        if (stop_now) begin
          // pass must include this vector's result, so use err_nxt, not err_q.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_nxt == '0);
          state_d = S_DONE;
        end else begin
          {a_d, b_d} = pair_nxt;
          settle_d   = SETTLE_M1;
          state_d    = S_HOLD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      match_q  <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      match_q  <= match_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign match_count = match_q;
  assign fail_a      = fail_a_q;
  assign fail_b      = fail_b_q;

endmodule

// File: tb/tb_eq_sweep_tester.sv
module tb_eq_sweep_tester;

  localparam int WIDTH = 4;

  typedef struct {
    int cycles;
    int pass;
    int err;
    int match;
    int fa;
    int fb;
    int fin_a;
    int fin_b;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_out, b_out;
  logic             eq_in;
  logic             busy, done, pass;
  logic [2*WIDTH:0] err_count, match_count;
  logic [WIDTH-1:0] fail_a, fail_b;

  logic             start3;
  logic [WIDTH-1:0] a3, b3;
  logic             eq3;
  logic             busy3, done3, pass3;
  logic [2*WIDTH:0] err3, match3;
  logic [WIDTH-1:0] fa3, fb3;

  int   mode;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  eq_sweep_tester #(.WIDTH(WIDTH), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out), .eq_in(eq_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .match_count(match_count),
    .fail_a(fail_a), .fail_b(fail_b)
  );

  eq_sweep_tester #(.WIDTH(WIDTH), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .a_out(a3), .b_out(b3), .eq_in(eq3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .match_count(match3),
    .fail_a(fa3), .fail_b(fb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator models: 0 correct, 1 stuck at 0, 2 inverted, 3 false equal at (5,9)
  function automatic logic comp(int m, int a, int b);
    case (m)
      1:       return 1'b0;
      2:       return (a != b);
      3:       return ((a == 5) && (b == 9)) ? 1'b1 : (a == b);
      default: return (a == b);
    endcase
  endfunction

  always_comb eq_in = comp(mode, int'(a_out), int'(b_out));
  always_comb eq3   = (a3 == b3);

  function automatic exp_t model(int m, int settle);
    exp_t e;
    bit   stopped;
    bit   stop_en;
    logic got, want;
    e = '{default: 0};
    stopped = 0;
`ifdef STOP_ON_FAIL_EN
    stop_en = 1;
`else
    stop_en = 0;
`endif
    for (int a = 0; a < (1 << WIDTH); a++) begin
      for (int b = 0; b < (1 << WIDTH); b++) begin
        if (!stopped) begin
          got  = comp(m, a, b);
          want = (a == b);
          e.cycles += settle + 1;
          e.fin_a = a;
          e.fin_b = b;
          if (got && want) e.match++;
          if (got != want) begin
            if (e.err == 0) begin
              e.fa = a;
              e.fb = b;
            end
            e.err++;
            if (stop_en) stopped = 1;
          end
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic sb_pop_check(input string tag, input int cyc, input int ps,
                              input int er, input int mt, input int fa,
                              input int fb, input int aa, input int bb);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_cycles"}, cyc, e.cycles);
    chk({tag, "_pass"},   ps,  e.pass);
    chk({tag, "_err"},    er,  e.err);
    chk({tag, "_match"},  mt,  e.match);
    chk({tag, "_fail_a"}, fa,  e.fa);
    chk({tag, "_fail_b"}, fb,  e.fb);
    chk({tag, "_a_out"},  aa,  e.fin_a);
    chk({tag, "_b_out"},  bb,  e.fin_b);
  endtask

  task automatic run_sweep(input string tag, input int m, input int restart_at);
    int cycles;
    mode = m;
    sb.push_back(model(m, 1));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    cycles = 0;
    while (!done && cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == restart_at);
    end
    start = 1'b0;
    chk({tag, "_busy_end"}, int'(busy), 0);
    sb_pop_check(tag, cycles, int'(pass), int'(err_count), int'(match_count),
                 int'(fail_a), int'(fail_b), int'(a_out), int'(b_out));
  endtask

  initial begin
    int cycles;
    int chg[3];
    int nchg;
    logic [WIDTH-1:0] prev_b;

    n_checks = 0;
    n_errors = 0;
    mode     = 0;
    start    = 1'b0;
    start3   = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a",     int'(a_out), 0);
    chk("rst_b",     int'(b_out), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_pass",  int'(pass), 0);
    chk("rst_err",   int'(err_count), 0);
    chk("rst_match", int'(match_count), 0);
    chk("rst_fa",    int'(fail_a), 0);
    chk("rst_fb",    int'(fail_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep("good",    0, 0);
    run_sweep("stuck0",  1, 0);
    run_sweep("invert",  2, 0);
    run_sweep("fault59", 3, 0);
    run_sweep("restart", 0, 100);

    // Abort a failing sweep mid-run; every result must clear immediately.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_a",     int'(a_out), 0);
    chk("abort_b",     int'(b_out), 0);
    chk("abort_busy",  int'(busy), 0);
    chk("abort_done",  int'(done), 0);
    chk("abort_err",   int'(err_count), 0);
    chk("abort_match", int'(match_count), 0);
    chk("abort_busy3", int'(busy3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("post_rst", 0, 0);

    // SETTLE=3 instance: longer sweep, each pair held four clocks.
    sb.push_back(model(0, 3));
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    cycles = 0;
    nchg   = 0;
    prev_b = b3;
    while (!done3 && cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (b3 != prev_b && nchg < 3) begin
        chg[nchg] = cycles;
        nchg++;
      end
      prev_b = b3;
    end
    chk("s3_nchg", nchg, 3);
    chk("s3_hold0", chg[0], 4);
    chk("s3_hold1", chg[1] - chg[0], 4);
    chk("s3_hold2", chg[2] - chg[1], 4);
    sb_pop_check("settle3", cycles, int'(pass3), int'(err3), int'(match3),
                 int'(fa3), int'(fb3), int'(a3), int'(b3));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
